fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end that replaces the single-register PC/tempPC path. It generates sequential PCs and issues requests to a 1-cycle-latency instruction memory. Returned words are buffered with their PCs in a DEPTH-entry FIFO and presented to decode through a valid/ready handshake. It supports redirect with squash of in-flight fetches, backpressure from decode, and misalignment flagging.

Parameters:
XLEN, 32, width of PC and instruction word
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0, PC fetched first after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
imem_req  out  1  fetch request valid this cycle
imem_addr  out  XLEN  fetch address (= pc_q)
imem_rvalid  in  1  response valid, exactly 1 cycle after an accepted req
imem_rdata  in  XLEN  instruction word, valid with imem_rvalid
redirect_valid  in  1  branch/jump redirect from EX
redirect_pc  in  XLEN  redirect target
out_valid  out  1  FIFO head valid to decode
out_ready  in  1  decode accepts head
out_instr  out  XLEN  head instruction
out_pc  out  XLEN  head PC
out_pc_plus_4  out  XLEN  out_pc + 4, modulo 2^XLEN
misalign_err  out  1  sticky: a redirect_pc had bits[1:0] != 0

Behaviour:
- Reset (rst==0 at edge):
  - pc_q <= RESET_PC; FIFO empty; inflight <= 0; epoch <= 0; misalign_err <= 0.
  - While rst==0: imem_req=0, out_valid=0; out_instr/out_pc/out_pc_plus_4 read 0 when out_valid=0.
  - Reset overrides everything, including mid-flight responses, which are dropped.
- Accept: a request is accepted when imem_req=1 at an edge. Then pc_q <= pc_q+4 (wraps), inflight <= 1, and req_epoch <= epoch.
- Credit: pop = out_valid & out_ready. imem_req = rst & ~redirect_valid & (count + inflight - pop < DEPTH). The FIFO therefore never overflows. An imem_rvalid arriving when no request is inflight is ignored.
- Push: at an edge with imem_rvalid & inflight & (req_epoch==epoch) & ~redirect_valid, write {imem_rdata, PC of that request} at the tail. inflight clears when the response arrives.
- Pop: at an edge with pop, advance the head. Push and pop in the same cycle leave count unchanged, including when the FIFO is full or empty-plus-push.
- Output: out_valid = (count != 0) & ~redirect_valid. Outputs are registered-FIFO reads; there is no bypass from imem_rdata to out.
- Latency: first request in the cycle after reset release (cycle 0). Response in cycle 1. out_valid rises in cycle 2.
- Throughput: 1 instruction/cycle sustained with out_ready=1 and DEPTH>=2.
- Redirect (redirect_valid=1 at edge) has priority over push, pop and fetch:
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}; FIFO cleared; epoch toggles.
  - A response for a pre-redirect request arriving next cycle is discarded by epoch mismatch.
  - In the redirect cycle imem_req=0 and out_valid=0; the first new request is issued the following cycle.
  - If redirect_pc[1:0] != 0, misalign_err <= 1 (sticky until reset).
- Back-to-back redirects: each one re-targets; only the last target is fetched.
- Stall: with out_ready=0, the FIFO fills to DEPTH, then imem_req=0 and pc_q holds. Fetch resumes in the cycle a pop occurs.
- Width: PC arithmetic is unsigned XLEN bits; 32'hFFFF_FFFC + 4 = 0. count is clog2(DEPTH)+1 bits.

Test Plan:
- Reset release, imem returns addr^32'hA5A5_0000, out_ready=1 -> imem_addr 0,4,8,...; out_valid first high cycle 2 with out_pc=0, out_pc_plus_4=4; then 1 instr/cycle in order.
- out_ready=0 from cycle 0, DEPTH=4 -> exactly 4 requests (0,4,8,C), imem_req=0 after, pc_q=0x10; raise out_ready -> pops 0,4,8,C, and fetch of 0x10 starts the same cycle as the first pop.
- Redirect to 0x100 while FIFO holds 3 entries and one request is inflight -> out_valid=0 that cycle; stale response dropped; next out_pc=0x100.
- Redirect to 0x102 -> misalign_err=1 persists; fetch resumes at 0x100; cleared only by rst=0.
- RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0; out_pc_plus_4 of FFFF_FFFC reads 0.
- Assert rst=0 with a request inflight and FIFO full -> next cycle out_valid=0, imem_req=0; after release, refetch from RESET_PC with no stale words delivered.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle imem,
// DEPTH-entry {instr, pc} queue to decode, redirect squash via epoch.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_4,
  output logic            misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  fq_entry_t       mem [DEPTH];
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic            epoch;
  logic            req_epoch;

  logic            pop;
  logic            push;
  logic [CW:0]     occ;
  fq_entry_t       head_e;

  // Occupancy counts the inflight word so a response always has a slot.
  always_comb begin
    occ = {1'b0, count}
        + (CW+1)'(inflight)
        - (CW+1)'(pop);
  end

  assign out_valid = rst & (count != '0)
                   & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign imem_req  = rst & ~redirect_valid
                   & (occ < DEPTH_W);
  assign imem_addr = pc_q;
  assign push      = imem_rvalid & inflight
                   & (req_epoch == epoch)
                   & ~redirect_valid;

  assign head_e        = mem[head];
  assign out_instr     = out_valid ? head_e.instr : '0;
  assign out_pc        = out_valid ? head_e.pc : '0;
  assign out_pc_plus_4 = out_valid
                       ? head_e.pc + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[tail] <= '{instr: imem_rdata, pc: req_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      req_pc       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      epoch        <= 1'b0;
      req_epoch    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (imem_req) begin
        inflight  <= 1'b1;
        req_pc    <= pc_q;
        req_epoch <= epoch;
      end else if (imem_rvalid) begin
        inflight  <= 1'b0;
      end
      if (redirect_valid) begin
        pc_q  <= {redirect_pc[XLEN-1:2], 2'b00};
        head  <= '0;
        tail  <= '0;
        count <= '0;
        epoch <= ~epoch;
        if (redirect_pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end else begin
        if (imem_req) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (push) begin
          tail <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed per-cycle vector bench for fetch_queue_unit, plus
// wrap-around and reset-while-full sequences on a second instance.
module tb_fetch_queue_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        ov;
  logic        rdy = 1'b0;
  logic [31:0] instr, pc, pc4;
  logic        mis;

  logic        w_rst = 1'b0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_ov;
  logic        w_rdy = 1'b0;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic        w_mis;

  fetch_queue_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(req), .imem_addr(addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .redirect_valid(rv), .redirect_pc(rpc),
    .out_valid(ov), .out_ready(rdy),
    .out_instr(instr), .out_pc(pc),
    .out_pc_plus_4(pc4), .misalign_err(mis)
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_ov), .out_ready(w_rdy),
    .out_instr(w_instr), .out_pc(w_pc),
    .out_pc_plus_4(w_pc4), .misalign_err(w_mis)
  );

  always @(posedge clk) begin
    rvalid   <= req;
    rdata    <= addr ^ KEY;
    w_rvalid <= w_req;
    w_rdata  <= w_addr ^ KEY;
  end

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic r, logic v, logic [31:0] p, logic d,
    logic q, logic [31:0] a, logic o,
    logic [31:0] h, logic m);
    vec_t t;
    t.r = r; t.rv = v; t.rpc = p; t.rdy = d;
    t.e_req = q; t.e_addr = a; t.e_ov = o;
    t.e_pc = h; t.e_mis = m;
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t tv [31];

  initial begin
    logic [31:0] e_in, e_p4;
    tv[0]  = mk(0,0,32'h0,  1, 0,32'h0,  0,32'h0,  0);
    tv[1]  = mk(1,0,32'h0,  1, 1,32'h0,  0,32'h0,  0);
    tv[2]  = mk(1,0,32'h0,  1, 1,32'h4,  0,32'h0,  0);
    tv[3]  = mk(1,0,32'h0,  1, 1,32'h8,  1,32'h0,  0);
    tv[4]  = mk(1,0,32'h0,  1, 1,32'hC,  1,32'h4,  0);
    tv[5]  = mk(1,0,32'h0,  1, 1,32'h10, 1,32'h8,  0);
    tv[6]  = mk(1,0,32'h0,  0, 1,32'h14, 1,32'hC,  0);
    tv[7]  = mk(1,0,32'h0,  0, 1,32'h18, 1,32'hC,  0);
    tv[8]  = mk(1,0,32'h0,  0, 0,32'h1C, 1,32'hC,  0);
    tv[9]  = mk(1,0,32'h0,  0, 0,32'h1C, 1,32'hC,  0);
    tv[10] = mk(1,0,32'h0,  1, 1,32'h1C, 1,32'hC,  0);
    tv[11] = mk(1,0,32'h0,  1, 1,32'h20, 1,32'h10, 0);
    tv[12] = mk(1,1,32'h100,1, 0,32'h24, 0,32'h0,  0);
    tv[13] = mk(1,0,32'h0,  1, 1,32'h100,0,32'h0,  0);
    tv[14] = mk(1,0,32'h0,  1, 1,32'h104,0,32'h0,  0);
    tv[15] = mk(1,0,32'h0,  1, 1,32'h108,1,32'h100,0);
    tv[16] = mk(1,1,32'h102,1, 0,32'h10C,0,32'h0,  0);
    tv[17] = mk(1,0,32'h0,  1, 1,32'h100,0,32'h0,  1);
    tv[18] = mk(1,0,32'h0,  1, 1,32'h104,0,32'h0,  1);
    tv[19] = mk(1,0,32'h0,  1, 1,32'h108,1,32'h100,1);
    tv[20] = mk(1,1,32'h200,1, 0,32'h10C,0,32'h0,  1);
    tv[21] = mk(1,1,32'h300,1, 0,32'h200,0,32'h0,  1);
    tv[22] = mk(1,0,32'h0,  1, 1,32'h300,0,32'h0,  1);
    tv[23] = mk(1,0,32'h0,  1, 1,32'h304,0,32'h0,  1);
    tv[24] = mk(1,0,32'h0,  1, 1,32'h308,1,32'h300,1);
    tv[25] = mk(1,0,32'h0,  0, 1,32'h30C,1,32'h304,1);
    tv[26] = mk(1,0,32'h0,  0, 1,32'h310,1,32'h304,1);
    tv[27] = mk(0,0,32'h0,  0, 0,32'h314,0,32'h0,  1);
    tv[28] = mk(1,0,32'h0,  1, 1,32'h0,  0,32'h0,  0);
    tv[29] = mk(1,0,32'h0,  1, 1,32'h4,  0,32'h0,  0);
    tv[30] = mk(1,0,32'h0,  1, 1,32'h8,  1,32'h0,  0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 31; i++) begin
      cyc();
      rst = tv[i].r;
      rv  = tv[i].rv;
      rpc = tv[i].rpc;
      rdy = tv[i].rdy;
      @(negedge clk);
      e_in = tv[i].e_ov ? (tv[i].e_pc ^ KEY) : 32'h0;
      e_p4 = tv[i].e_ov ? (tv[i].e_pc + 32'h4) : 32'h0;
      chk($sformatf("v%0d req", i), 32'(req), 32'(tv[i].e_req));
      chk($sformatf("v%0d addr", i), addr, tv[i].e_addr);
      chk($sformatf("v%0d ov", i), 32'(ov), 32'(tv[i].e_ov));
      chk($sformatf("v%0d pc", i), pc, tv[i].e_pc);
      chk($sformatf("v%0d instr", i), instr, e_in);
      chk($sformatf("v%0d pc4", i), pc4, e_p4);
      chk($sformatf("v%0d mis", i), 32'(mis), 32'(tv[i].e_mis));
    end

    // PC wrap through zero
    cyc(); w_rst = 1'b1; w_rdy = 1'b1;
    @(negedge clk);
    chk("wrap c0 req", 32'(w_req), 32'h1);
    chk("wrap c0 addr", w_addr, 32'hFFFF_FFF8);
    cyc(); @(negedge clk);
    chk("wrap c1 addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap c1 ov", 32'(w_ov), 32'h0);
    cyc(); @(negedge clk);
    chk("wrap c2 addr", w_addr, 32'h0);
    chk("wrap c2 pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap c2 pc4", w_pc4, 32'hFFFF_FFFC);
    cyc(); @(negedge clk);
    chk("wrap c3 addr", w_addr, 32'h4);
    chk("wrap c3 pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap c3 pc4", w_pc4, 32'h0);
    chk("wrap c3 instr", w_instr, 32'h5A5A_FFFC);

    // Fill the queue, then reset on top of it
    cyc(); w_rdy = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    chk("full req", 32'(w_req), 32'h0);
    chk("full ov", 32'(w_ov), 32'h1);
    cyc(); w_rst = 1'b0;
    @(negedge clk);
    chk("rst req", 32'(w_req), 32'h0);
    chk("rst ov", 32'(w_ov), 32'h0);
    chk("rst instr", w_instr, 32'h0);
    cyc(); w_rst = 1'b1; w_rdy = 1'b1;
    @(negedge clk);
    chk("rel c0 addr", w_addr, 32'hFFFF_FFF8);
    chk("rel c0 req", 32'(w_req), 32'h1);
    chk("rel c0 ov", 32'(w_ov), 32'h0);
    cyc(); @(negedge clk);
    chk("rel c1 ov", 32'(w_ov), 32'h0);
    cyc(); @(negedge clk);
    chk("rel c2 ov", 32'(w_ov), 32'h1);
    chk("rel c2 pc", w_pc, 32'hFFFF_FFF8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
